// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO slice.
package fifo_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 11;
    // almost_full default sits this many entries below the top of the FIFO
    localparam int AF_MARGIN     = 4;
    localparam int AE_THRESH_DEF = 4;

    // Number of entries addressed by an addr_w-bit index
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one enabled read port with a
// registered output. The array itself is never reset; only the output
// register is, so the FIFO can present a known r_data after reset.
module sdp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_reg;

    // Write port: store the incoming word when enabled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: capture the addressed word on rd_en, otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointer, occupancy, flag and sticky-error logic around
// an sdp_ram. Pointers carry one extra wrap bit; the RAM index is the low
// ADDR_W bits. Flags decode from the registered count.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int AF_THRESH = depth_of(ADDR_W) - AF_MARGIN,
    parameter int AE_THRESH = AE_THRESH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clear_err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(depth_of(ADDR_W));
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    // Reject threshold settings that would make the almost flags meaningless
    if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > depth_of(ADDR_W)) begin : g_bad_thresh
        $error("sync_fifo_ctrl: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= depth");
    end

    logic [CNT_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             r_valid_reg, r_valid_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;
    logic             wr_acc, rd_acc;

    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);

    // A write into a full FIFO or a read from an empty one is dropped
    assign wr_acc = w_en && !full;
    assign rd_acc = r_en && !empty;

    // Next-state for pointers, occupancy, read strobe and sticky errors
    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        r_valid_next   = rd_acc;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + CNT_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_next = rd_ptr_reg + CNT_W'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        // A new error event outranks a simultaneous clear
        if (w_en && full) begin
            overflow_next = 1'b1;
        end else if (clear_err) begin
            overflow_next = 1'b0;
        end
        if (r_en && empty) begin
            underflow_next = 1'b1;
        end else if (clear_err) begin
            underflow_next = 1'b0;
        end
    end

    // Controller state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            r_valid_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            r_valid_reg   <= r_valid_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Reset also gates the RAM strobes so a reset cycle never disturbs storage
    sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc && !reset),
        .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
        .wr_data (w_data),
        .rd_en   (rd_acc && !reset),
        .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
        .rd_data (r_data)
    );

    assign r_valid   = r_valid_reg;
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl at depth 8 (AF_THRESH=4, AE_THRESH=2).
module tb_sync_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          w_en;
    logic [DW-1:0] w_data;
    logic          r_en;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          clear_err;

    int n_tests = 0;
    int n_fail  = 0;

    sync_fifo_ctrl #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .AF_THRESH (4),
        .AE_THRESH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .w_en         (w_en),
        .w_data       (w_data),
        .r_en         (r_en),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clear_err    (clear_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_tests++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w_en = 1'b0; r_en = 1'b0; clear_err = 1'b0; w_data = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_rvalid", 32'(r_valid), 32'd0);
        chk("rst_rdata", 32'(r_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        $display("[TB] reset checked");

        // Fill with 0x11..0x18
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; w_data = 8'(8'h11 + i);
            tick();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_af", 32'(almost_full), (i + 1 >= 4) ? 32'd1 : 32'd0);
            chk("fill_ae", 32'(almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
            $display("[TB] write 0x%0h count=%0d", w_data, count);
        end
        idle_inputs();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_empty", 32'(empty), 32'd0);

        // Drain, checking order and one-cycle latency
        for (int i = 0; i < 8; i++) begin
            r_en = 1'b1;
            tick();
            chk("drain_rvalid", 32'(r_valid), 32'd1);
            chk("drain_rdata", 32'(r_data), 32'(8'h11 + i));
            chk("drain_count", 32'(count), 32'(7 - i));
            $display("[TB] read 0x%0h count=%0d", r_data, count);
        end
        idle_inputs();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_full", 32'(full), 32'd0);
        chk("drain_unf", 32'(underflow), 32'd0);
        tick();
        chk("idle_rvalid", 32'(r_valid), 32'd0);
        chk("idle_hold", 32'(r_data), 32'h18);

        // Refill with 0x21..0x28, then write 0xAA while full
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; w_data = 8'(8'h21 + i);
            tick();
        end
        w_data = 8'hAA;
        tick();
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        $display("[TB] write 0xaa while full overflow=%0d", overflow);
        w_en = 1'b0; clear_err = 1'b1;
        tick();
        chk("ovf_clear", 32'(overflow), 32'd0);
        w_en = 1'b1;
        tick();
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        w_en = 1'b0;
        tick();
        chk("ovf_clear2", 32'(overflow), 32'd0);
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            r_en = 1'b1;
            tick();
            chk("refill_rdata", 32'(r_data), 32'(8'h21 + i));
            $display("[TB] read 0x%0h", r_data);
        end
        idle_inputs();
        chk("refill_empty", 32'(empty), 32'd1);

        // Simultaneous read/write on empty: write wins, underflow flagged
        w_en = 1'b1; r_en = 1'b1; w_data = 8'h05;
        tick();
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_count", 32'(count), 32'd1);
        chk("unf_rvalid", 32'(r_valid), 32'd0);
        w_en = 1'b0;
        tick();
        chk("unf_rdata", 32'(r_data), 32'h05);
        chk("unf_rvalid2", 32'(r_valid), 32'd1);
        chk("unf_count2", 32'(count), 32'd0);
        $display("[TB] simultaneous on empty -> read 0x%0h", r_data);
        idle_inputs();

        // Half full then 20 cycles of simultaneous read/write across wrap
        for (int i = 0; i < 4; i++) begin
            w_en = 1'b1; w_data = 8'(8'h30 + i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            w_en = 1'b1; r_en = 1'b1; w_data = 8'(8'h40 + i);
            tick();
            chk("stream_count", 32'(count), 32'd4);
            chk("stream_rvalid", 32'(r_valid), 32'd1);
            chk("stream_rdata", 32'(r_data), (i < 4) ? 32'(8'h30 + i) : 32'(8'h40 + i - 4));
            $display("[TB] stream wr 0x%0h rd 0x%0h count=%0d", w_data, r_data, count);
        end
        idle_inputs();

        // Reset mid-stream with count=5 and underflow still set
        w_en = 1'b1; w_data = 8'h50;
        tick();
        chk("pre_rst_count", 32'(count), 32'd5);
        chk("pre_rst_unf", 32'(underflow), 32'd1);
        reset = 1'b1; w_en = 1'b1; r_en = 1'b1; w_data = 8'h99;
        tick();
        reset = 1'b0;
        idle_inputs();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_rvalid", 32'(r_valid), 32'd0);
        chk("mid_rst_rdata", 32'(r_data), 32'd0);
        chk("mid_rst_unf", 32'(underflow), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        w_en = 1'b1; w_data = 8'h77;
        tick();
        w_en = 1'b0; r_en = 1'b1;
        tick();
        idle_inputs();
        chk("post_rst_rdata", 32'(r_data), 32'h77);
        chk("post_rst_rvalid", 32'(r_valid), 32'd1);
        chk("post_rst_count", 32'(count), 32'd0);
        $display("[TB] after reset read 0x%0h", r_data);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
